// File: rtl/power_scheduler.sv
// power_scheduler
//   Shares the ship power reserve between three life-support consumers:
//   shield regen (0), thermal control (1) and O2 generation (2).
//   Consumers use a req/gnt/done handshake. Arbitration combines a
//   mode-based preferred consumer with round-robin fairness. Each grant
//   lasts for a bounded slot. When the reserve is low, only O2 is served.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous reset, active low
//   pwr_lvl   in   N   current power reserve
//   chrg      in   1   charging active (also clears pwr_draw)
//   mode      in   4   ship mode: 4'b0100 defence, 4'b1000 stealth
//   fatal     in   1   life-support fatal flag
//   req       in   3   per-consumer request level, held until granted
//   done      in   3   per-consumer completion pulse
//   gnt       out  3   one-hot grant, registered
//   busy      out  1   state != IDLE
//   low_pwr   out  1   registered (pwr_lvl <= RESERVE)
//   pwr_draw  out  N   accumulated draw units, saturating
//   state     out  2   IDLE=0, GRANT=1, RECOVER=2, LOCKOUT=3
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no grant; picks a winner among eligible requesters
// GRANT   | one consumer holds gnt for up to SLOT cycles
// RECOVER | single dead cycle between consecutive grants
// LOCKOUT | fatal seen; only O2 may draw until fatal is clear for 2 cycles
module power_scheduler #(
    parameter int N       = 8,
    parameter int SLOT    = 4,
    parameter int RESERVE = 16,
    parameter int COST    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pwr_lvl,
    input  logic         chrg,
    input  logic [3:0]   mode,
    input  logic         fatal,
    input  logic [2:0]   req,
    input  logic [2:0]   done,
    output logic [2:0]   gnt,
    output logic         busy,
    output logic         low_pwr,
    output logic [N-1:0] pwr_draw,
    output logic [1:0]   state
);

    localparam int SW = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT - 1);
    localparam logic [N-1:0]  RES_V     = N'(RESERVE);
    localparam logic [N-1:0]  COST_V    = N'(COST);
    localparam logic [N-1:0]  DRAW_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RECOVER = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t         state_q, state_nxt;
    logic [1:0]     rr_ptr, rr_nxt;
    logic [SW-1:0]  slot_cnt, slot_nxt;
    logic           lock_cnt, lock_nxt;
    logic [2:0]     gnt_nxt;

    logic [2:0]     elig;
    logic [2:0]     cand;
    logic           pref_vld;
    logic [1:0]     pref_idx;
    logic           win_vld;
    logic [1:0]     win_idx;
    logic [1:0]     rr_idx;
    logic [1:0]     cur_idx;
    logic           release_g;
    logic [N:0]     draw_sum;

    function automatic logic [1:0] next3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    // O2 stays eligible at zero reserve while charging, so life support
    // never starves during recharge.
    always_comb begin
        elig[0] = (pwr_lvl > RES_V);
        elig[1] = (pwr_lvl > RES_V);
        elig[2] = (pwr_lvl != '0) || chrg;
    end

    assign cand = req & elig;

    always_comb begin
        pref_vld = 1'b0;
        pref_idx = 2'd0;
        if (mode == 4'b0100) begin
            pref_vld = 1'b1;
            pref_idx = 2'd0;
        end else if (mode == 4'b1000) begin
            pref_vld = 1'b1;
            pref_idx = 2'd1;
        end
    end

    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        rr_idx  = rr_ptr;
        if (pref_vld && cand[pref_idx]) begin
            win_vld = 1'b1;
            win_idx = pref_idx;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!win_vld && cand[rr_idx]) begin
                    win_vld = 1'b1;
                    win_idx = rr_idx;
                end
                rr_idx = next3(rr_idx);
            end
        end
    end

    always_comb begin
        cur_idx = 2'd0;
        if (gnt[1])
            cur_idx = 2'd1;
        else if (gnt[2])
            cur_idx = 2'd2;
    end

    assign release_g = done[cur_idx] || !req[cur_idx] || !elig[cur_idx] ||
                       (slot_cnt == SLOT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (fatal)
                    state_nxt = S_LOCKOUT;
                else if (win_vld)
                    state_nxt = S_GRANT;
            end
            S_GRANT: begin
                if (fatal)
                    state_nxt = S_LOCKOUT;
                else if (release_g)
                    state_nxt = S_RECOVER;
            end
            S_RECOVER: state_nxt = S_IDLE;
            S_LOCKOUT: begin
                if (!fatal && lock_cnt)
                    state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered grant and its bookkeeping
    always_comb begin
        gnt_nxt  = gnt;
        rr_nxt   = rr_ptr;
        slot_nxt = slot_cnt;
        lock_nxt = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt_nxt = 3'b000;
                if (!fatal && win_vld) begin
                    gnt_nxt  = onehot(win_idx);
                    slot_nxt = '0;
                end
            end
            S_GRANT: begin
                slot_nxt = slot_cnt + 1'b1;
                if (fatal) begin
                    // Fatal is not a release: the fairness pointer stays put.
                    gnt_nxt = 3'b000;
                end else if (release_g) begin
                    gnt_nxt = 3'b000;
                    rr_nxt  = next3(cur_idx);
                end
            end
            S_RECOVER: gnt_nxt = 3'b000;
            S_LOCKOUT: begin
                // lock_cnt remembers one fatal-free cycle; a second one exits.
                lock_nxt = !fatal;
                if (!fatal && lock_cnt)
                    gnt_nxt = 3'b000;
                else
                    gnt_nxt = (req[2] && elig[2]) ? 3'b100 : 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= 3'b000;
            rr_ptr   <= 2'd0;
            slot_cnt <= '0;
            lock_cnt <= 1'b0;
        end else begin
            gnt      <= gnt_nxt;
            rr_ptr   <= rr_nxt;
            slot_cnt <= slot_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    // Draw is charged for every cycle a grant is held, in GRANT or LOCKOUT.
    assign draw_sum = {1'b0, pwr_draw} + {1'b0, COST_V};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwr_draw <= '0;
            low_pwr  <= 1'b0;
        end else begin
            low_pwr <= (pwr_lvl <= RES_V);
            if (chrg)
                pwr_draw <= '0;
            else if (gnt != 3'b000)
                pwr_draw <= draw_sum[N] ? DRAW_MAX : draw_sum[N-1:0];
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign state = state_q;

endmodule
